inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Fetch front end that drives the address side of inst_mem and consumes its combinational instruction output.
- Holds the program counter and issues sequential word addresses.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, and halts on an all-zero instruction word.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- FIFO_DEPTH, 2, number of {pc, inst} entries buffered (power of two, ≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- imem_addr  output  32  address to inst_mem; always equals current PC register.
- imem_inst  input  32  instruction word from inst_mem for imem_addr (same-cycle, combinational).
- redirect_valid  input  1  taken branch/jump request from execute.
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0 on load.
- out_valid  output  1  FIFO head holds a valid entry.
- out_ready  input  1  decode accepts head this cycle.
- out_inst  output  32  instruction at FIFO head.
- out_pc  output  32  address of out_inst.
- halted  output  1  high while in HALT state.
- fetch_count  output  32  number of instructions pushed into FIFO since reset; wraps at 2^32.

Behaviour:
- Reset (reset==0 at a rising edge):
  - pc=RESET_PC, state=IDLE, FIFO empty, fetch_count=0.
  - out_valid=0, out_inst=0, out_pc=0, halted=0.
  - imem_addr=RESET_PC.
  - Reset asserted mid-operation discards all FIFO contents and any pending redirect.
- States:
  - IDLE: one bubble cycle after reset; no push; moves to RUN unconditionally.
  - RUN: fetching.
  - HALT: PC frozen, no push; FIFO keeps draining to decode.
- RUN push rule:
  - push = !redirect_valid && imem_inst!=0 && (count<FIFO_DEPTH || pop).
  - On push: write {pc, imem_inst} at tail, pc<=pc+4 (32-bit wrap: 32'hFFFFFFFC -> 0), fetch_count+=1.
  - No push due to full FIFO: pc holds; imem_addr stable.
- Halt: in RUN, imem_inst==32'h0 and no redirect -> nothing pushed, pc holds, state<=HALT, halted=1 from next cycle.
- Pop: pop = out_valid && out_ready. Head advances at the edge.
  - Simultaneous push and pop: count unchanged.
- Redirect (highest priority, any state except IDLE):
  - FIFO cleared, pc<=redirect_pc & ~3, state<=RUN, halted<=0.
  - The instruction presented on imem_inst this cycle is dropped.
  - A pop in the same cycle still completes (decode owns the transfer); the FIFO is cleared regardless.
  - Redirect in IDLE is ignored.
- Latency:
  - First out_valid is asserted 2 cycles after reset deasserts (IDLE, then push).
  - After a redirect, out_valid=0 next cycle; the target instruction is valid the cycle after.
- Outputs: out_valid/out_inst/out_pc are taken directly from FIFO head registers (no combinational path from imem_inst). When empty: out_valid=0; out_inst/out_pc hold their last values.
- Full FIFO with out_ready=0: entries and pc stable indefinitely; no drops, no duplicates.

Test Plan:
- Sequential fetch: memory words 00100293, 00300313, 0062B223, 0062E3B3 at 0..C, out_ready=1 -> out_pc 0,4,8,C with those insts in consecutive cycles starting cycle 2 after reset release; fetch_count=4.
- Backpressure: out_ready=0 for 5 cycles -> FIFO fills with FIFO_DEPTH entries, imem_addr stuck at 8 (DEPTH=2), out_pc=0 held. Release -> entries at 0, 4, 8 delivered in order with no gap or duplicate.
- Redirect: while fetching at 8, redirect_valid=1, redirect_pc=32'h1E -> next cycle out_valid=0, imem_addr=32'h1C. Cycle after, out_pc=1C. Stale entries never appear.
- Halt: word at 0x24 is 0 -> halted=1, imem_addr stays 24, preceding entries drain. Then redirect to 0 -> halted=0 and fetch resumes from 0.
- PC wrap: RESET_PC=32'hFFFFFFFC -> out_pc FFFFFFFC then 00000000.
- Reset mid-stream: reset=0 with 2 entries buffered -> next cycle out_valid=0, imem_addr=RESET_PC, fetch_count=0, halted=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch front end: owns the PC, reads inst_mem combinationally,
// buffers {pc, inst} pairs in a small FIFO and hands them to decode.
//
// Decode handshake: out_valid marks a valid FIFO head; a transfer happens on
// a rising edge where out_valid && out_ready. out_valid never depends on
// out_ready, and out_pc/out_inst stay stable while out_valid && !out_ready.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [1:0]  dbg_state_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        fc_q, fc_d;
  logic [PTR_W-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        mem_pc_q   [FIFO_DEPTH];
  logic [31:0]        mem_pc_d   [FIFO_DEPTH];
  logic [31:0]        mem_inst_q [FIFO_DEPTH];
  logic [31:0]        mem_inst_d [FIFO_DEPTH];
  logic               out_valid_q, out_valid_d;
  logic [31:0]        out_pc_q, out_pc_d;
  logic [31:0]        out_inst_q, out_inst_d;
  logic               pop, push;

  // Next-state: FSM, PC, FIFO pointers/storage and the registered head view.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fc_d       = fc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    push       = 1'b0;
    pop        = out_valid_q && out_ready;

    // A pop completes even when a redirect clears the FIFO below.
    if (pop) begin
      rd_d  = rd_q + PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        // Single bubble after reset; redirects are ignored here.
        state_d = S_RUN;
      end
      S_RUN, S_HALT: begin
        if (redirect_valid) begin
          rd_d    = '0;
          wr_d    = '0;
          cnt_d   = '0;
          pc_d    = redirect_pc & 32'hFFFF_FFFC;
          state_d = S_RUN;
        end else if (state_q == S_RUN) begin
          if (imem_inst == 32'h0) begin
            state_d = S_HALT;
          end else if ((cnt_q != DEPTH_C) || pop) begin
            push = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      mem_pc_d[wr_q]   = pc_q;
      mem_inst_d[wr_q] = imem_inst;
      wr_d             = wr_q + PTR_W'(1);
      cnt_d            = cnt_d + CNT_W'(1);
      pc_d             = pc_q + 32'd4;
      fc_d             = fc_q + 32'd1;
    end

    // Head registers follow the next head; they hold when the FIFO empties.
    out_valid_d = (cnt_d != '0);
    if (out_valid_d) begin
      out_pc_d   = mem_pc_d[rd_d];
      out_inst_d = mem_inst_d[rd_d];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      fc_q        <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_pc_q[i]   <= '0;
        mem_inst_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fc_q        <= fc_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      mem_pc_q    <= mem_pc_d;
      mem_inst_q  <= mem_inst_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_inst    = out_inst_q;
  assign halted      = (state_q == S_HALT);
  assign fetch_count = fc_q;
  assign dbg_state_o = state_q;

endmodule
